// File: rtl/down_counter_timer_pkg.sv
// -----------------------------------------------------------------------------
// down_counter_timer_pkg
// Shared definitions for the loadable down-counter timer.
//   state_t        : 1-bit controller state (IDLE=0, RUN=1)
//   WIDTH_DEFAULT  : default counter/load width in bits
// -----------------------------------------------------------------------------
package down_counter_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WIDTH_DEFAULT = 4;

endpackage : down_counter_timer_pkg

// File: rtl/down_counter_timer_dec_bout.sv
// -----------------------------------------------------------------------------
// down_counter_timer_dec_bout
// WIDTH-bit subtract-one with borrow-out. This is the decrementing twin of
// the adder-with-carry-out: it uses the same carry chain with the constant
// operand fixed at 1.
// Ports:
//   I0   in  WIDTH  minuend
//   O    out WIDTH  I0 - 1 (modulo 2^WIDTH)
//   BOUT out 1      borrow out, high only when I0 == 0
// -----------------------------------------------------------------------------
module down_counter_timer_dec_bout #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] I0,
    output logic [WIDTH-1:0] O,
    output logic             BOUT
);

    logic [WIDTH:0] diff;

    // The extra top bit captures the borrow out of the subtraction.
    assign diff = {1'b0, I0} - (WIDTH+1)'(1);
    assign O    = diff[WIDTH-1:0];
    assign BOUT = diff[WIDTH];

endmodule : down_counter_timer_dec_bout

// File: rtl/down_counter_timer.sv
// -----------------------------------------------------------------------------
// down_counter_timer
// Loadable down-counter timer. START captures I and the count then steps
// down by one on each CE cycle. A one-cycle DONE pulse marks the first
// cycle O shows zero. With AUTO_RELOAD=1 the captured value is reloaded on
// the next enabled cycle, which gives a periodic tick of N+1 enabled cycles.
// Ports:
//   CLK    in  1      clock, all state on rising edge
//   RESET  in  1      synchronous, active-high reset
//   I      in  WIDTH  load value, sampled on an accepted START
//   START  in  1      start request, accepted only in IDLE
//   STOP   in  1      abort request, effective only in RUN
//   CE     in  1      count enable in RUN
//   O      out WIDTH  current count (registered)
//   BUSY   out 1      high while running (registered)
//   DONE   out 1      terminal pulse (registered)
// -----------------------------------------------------------------------------
module down_counter_timer
    import down_counter_timer_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             START,
    input  logic             STOP,
    input  logic             CE,
    output logic [WIDTH-1:0] O,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_next;
    logic [WIDTH-1:0] count_next;
    logic             done_next;
    logic [WIDTH-1:0] dec;
    logic             bout;

    down_counter_timer_dec_bout #(
        .WIDTH (WIDTH)
    ) u_dec (
        .I0   (O),
        .O    (dec),
        .BOUT (bout)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            O      <= '0;
            reload <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= state_next;
            O      <= count_next;
            reload <= reload_next;
            BUSY   <= (state_next == RUN);
            DONE   <= done_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = O;
        reload_next = reload;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                if (START) begin
                    if (I != '0) begin
                        count_next  = I;
                        reload_next = I;
                        state_next  = RUN;
                    end else begin
                        // A zero load completes immediately without running.
                        count_next = '0;
                        done_next  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (STOP) begin
                    state_next = IDLE;
                end else if (CE) begin
                    if (bout) begin
                        // Count sits at zero: only reachable with auto-reload,
                        // where the zero cycle is followed by the reload.
                        count_next = reload;
                    end else begin
                        count_next = dec;
                        if (dec == '0) begin
                            done_next = 1'b1;
                            if (!AUTO_RELOAD) begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule : down_counter_timer

// File: tb/tb_down_counter_timer.sv
// -----------------------------------------------------------------------------
// tb_down_counter_timer
// Bench for down_counter_timer. Two instances share one stimulus stream:
// u_os (one-shot) and u_ar (auto-reload). Each stimulus step pushes the
// expected registered outputs of one selected instance; a monitor pops and
// compares them after every rising edge.
// -----------------------------------------------------------------------------
module tb_down_counter_timer;

    localparam int W = 4;

    typedef struct packed {
        logic         sel;   // 0 = one-shot instance, 1 = auto-reload instance
        logic [W-1:0] o;
        logic         busy;
        logic         done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] i_val;
    logic         start;
    logic         stop;
    logic         ce;

    logic [W-1:0] o_os;
    logic         busy_os;
    logic         done_os;
    logic [W-1:0] o_ar;
    logic         busy_ar;
    logic         done_ar;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks   = 0;
    int    failures = 0;
    bit    stim_done = 1'b0;

    always #5 clk = ~clk;

    down_counter_timer #(
        .WIDTH       (W),
        .AUTO_RELOAD (1'b0)
    ) u_os (
        .CLK   (clk),
        .RESET (rst),
        .I     (i_val),
        .START (start),
        .STOP  (stop),
        .CE    (ce),
        .O     (o_os),
        .BUSY  (busy_os),
        .DONE  (done_os)
    );

    down_counter_timer #(
        .WIDTH       (W),
        .AUTO_RELOAD (1'b1)
    ) u_ar (
        .CLK   (clk),
        .RESET (rst),
        .I     (i_val),
        .START (start),
        .STOP  (stop),
        .CE    (ce),
        .O     (o_ar),
        .BUSY  (busy_ar),
        .DONE  (done_ar)
    );

    // Drive one cycle of inputs and record the outputs expected after the edge.
    task automatic step(input logic r, input logic s, input logic p, input logic c,
                        input logic [W-1:0] v, input logic sel,
                        input logic [W-1:0] eo, input logic eb, input logic ed,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst   = r;
        start = s;
        stop  = p;
        ce    = c;
        i_val = v;
        e.sel  = sel;
        e.o    = eo;
        e.busy = eb;
        e.done = ed;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compare after every rising edge that has a pending expectation.
    initial begin
        exp_t         e;
        string        nm;
        logic [W-1:0] ao;
        logic         ab;
        logic         ad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                ao = e.sel ? o_ar    : o_os;
                ab = e.sel ? busy_ar : busy_os;
                ad = e.sel ? done_ar : done_os;
                checks++;
                if (ao !== e.o || ab !== e.busy || ad !== e.done) begin
                    failures++;
                    $display("FAIL %s: got O=%0d BUSY=%0b DONE=%0b, expected O=%0d BUSY=%0b DONE=%0b",
                             nm, ao, ab, ad, e.o, e.busy, e.done);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ce = 1'b0; i_val = '0;

        // Reset with START asserted: nothing loads.
        step(1, 1, 0, 0, 4'd9, 0, 4'd0, 0, 0, "reset_os");
        step(1, 1, 0, 0, 4'd9, 1, 4'd0, 0, 0, "reset_ar");

        // One-shot, I=3, CE held high (CE ignored on the accepting edge).
        step(0, 1, 0, 1, 4'd3, 0, 4'd3, 1, 0, "os_load3");
        step(0, 0, 0, 1, 4'd0, 0, 4'd2, 1, 0, "os_cnt2");
        step(0, 0, 0, 1, 4'd0, 0, 4'd1, 1, 0, "os_cnt1");
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 1, "os_done");
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "os_hold0a");
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "os_hold0b");

        // CE gating, I=2, CE pattern 1,0,0,1,1.
        step(0, 1, 0, 1, 4'd2, 0, 4'd2, 1, 0, "ce_load2");
        step(0, 0, 0, 0, 4'd0, 0, 4'd2, 1, 0, "ce_gate_hold");
        step(0, 0, 0, 1, 4'd0, 0, 4'd1, 1, 0, "ce_cnt1");
        step(0, 0, 0, 0, 4'd0, 0, 4'd1, 1, 0, "ce_hold1a");
        step(0, 0, 0, 0, 4'd0, 0, 4'd1, 1, 0, "ce_hold1b");
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 1, "ce_done");

        // Auto-reload, I=2: 2,1,0,2,1,0,2 with START mid-run ignored.
        step(1, 0, 0, 0, 4'd0, 1, 4'd0, 0, 0, "ar_reset");
        step(0, 1, 0, 1, 4'd2, 1, 4'd2, 1, 0, "ar_load2");
        step(0, 0, 0, 1, 4'd0, 1, 4'd1, 1, 0, "ar_c1");
        step(0, 0, 0, 1, 4'd0, 1, 4'd0, 1, 1, "ar_done1");
        step(0, 0, 0, 1, 4'd0, 1, 4'd2, 1, 0, "ar_reload1");
        step(0, 1, 0, 1, 4'd5, 1, 4'd1, 1, 0, "ar_start_ignored");
        step(0, 0, 0, 1, 4'd0, 1, 4'd0, 1, 1, "ar_done2");
        step(0, 0, 0, 1, 4'd0, 1, 4'd2, 1, 0, "ar_reload2");
        step(0, 0, 1, 1, 4'd0, 1, 4'd2, 0, 0, "ar_stop");

        // Auto-reload, I=1: minimum DONE spacing, CE=0 holds at zero.
        step(0, 1, 0, 1, 4'd1, 1, 4'd1, 1, 0, "ar1_load");
        step(0, 0, 0, 1, 4'd0, 1, 4'd0, 1, 1, "ar1_done1");
        step(0, 0, 0, 1, 4'd0, 1, 4'd1, 1, 0, "ar1_reload");
        step(0, 0, 0, 1, 4'd0, 1, 4'd0, 1, 1, "ar1_done2");
        step(0, 0, 0, 0, 4'd0, 1, 4'd0, 1, 0, "ar1_hold0");
        step(0, 0, 0, 1, 4'd0, 1, 4'd1, 1, 0, "ar1_reload2");

        // Abort at O=5.
        step(1, 0, 0, 0, 4'd0, 0, 4'd0, 0, 0, "ab_reset");
        step(0, 1, 0, 1, 4'd9, 0, 4'd9, 1, 0, "ab_load9");
        step(0, 0, 0, 1, 4'd0, 0, 4'd8, 1, 0, "ab_c8");
        step(0, 0, 0, 1, 4'd0, 0, 4'd7, 1, 0, "ab_c7");
        step(0, 0, 0, 1, 4'd0, 0, 4'd6, 1, 0, "ab_c6");
        step(0, 0, 0, 1, 4'd0, 0, 4'd5, 1, 0, "ab_c5");
        step(0, 0, 1, 1, 4'd0, 0, 4'd5, 0, 0, "ab_stop");
        step(0, 0, 0, 1, 4'd0, 0, 4'd5, 0, 0, "ab_idle_hold");
        // START+STOP in IDLE loads; START+STOP in RUN stops.
        step(0, 1, 1, 1, 4'd9, 0, 4'd9, 1, 0, "ab_reload9");
        step(0, 1, 1, 1, 4'd3, 0, 4'd9, 0, 0, "ab_start_stop");
        step(0, 1, 0, 1, 4'd1, 0, 4'd1, 1, 0, "ab_load1");
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 1, "ab_done1");

        // START with I=0 completes immediately.
        step(0, 1, 0, 1, 4'd0, 0, 4'd0, 0, 1, "zero_load");
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "zero_after");

        // Maximum load counts fully down with no wrap.
        step(0, 1, 0, 1, 4'd15, 0, 4'd15, 1, 0, "max_load");
        for (int k = 14; k >= 1; k--) begin
            step(0, 0, 0, 1, 4'd0, 0, W'(k), 1, 0, "max_cnt");
        end
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 1, "max_done");
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "max_after");

        // Reset mid-run at O=7.
        step(0, 1, 0, 1, 4'd9, 0, 4'd9, 1, 0, "mr_load9");
        step(0, 0, 0, 1, 4'd0, 0, 4'd8, 1, 0, "mr_c8");
        step(0, 0, 0, 1, 4'd0, 0, 4'd7, 1, 0, "mr_c7");
        step(1, 1, 0, 1, 4'd9, 0, 4'd0, 0, 0, "mr_reset");
        step(0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, "mr_after");

        @(negedge clk);
        rst = 1'b0; start = 1'b0; stop = 1'b0; ce = 1'b0;
        stim_done = 1'b1;
    end

    // Finish once stimulus is exhausted and every expectation has been checked,
    // or when the cycle budget runs out.
    initial begin
        int cyc;
        cyc = 0;
        while (!(stim_done && exp_q.size() == 0) && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0 || !stim_done) begin
            failures++;
            $display("FAIL drain: pending=%0d stim_done=%0b, required pending=0 stim_done=1",
                     exp_q.size(), stim_done);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_down_counter_timer
